// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle adder: adds two NIB-nibble operands through one 4-bit ripple
// slice, LSB nibble first, holding the inter-nibble carry in a register.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIB = 4
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_start,
  input  logic [4*NIB-1:0] w_a,
  input  logic [4*NIB-1:0] w_b,
  input  logic             w_cin,
  output logic             w_busy,
  output logic             w_done,
  output logic [4*NIB-1:0] w_sum,
  output logic             w_cout,
  output logic             w_ovf
);

  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [NIB-1:0][3:0]     a_q, a_d;
  logic [NIB-1:0][3:0]     b_q, b_d;
  logic [NIB-1:0][3:0]     sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;

  logic [3:0]              slice_a, slice_b, slice_s;
  logic [4:0]              slice_c;

  // 4-bit ripple chain of full adders; carry-in comes from the carry register
  always_comb begin
    slice_a    = a_q[idx_q];
    slice_b    = b_q[idx_q];
    slice_c    = '0;
    slice_s    = '0;
    slice_c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_s[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
      slice_c[i+1] = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  // Next-state and datapath update selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (w_start) begin
          a_d     = w_a;
          b_d     = w_b;
          carry_d = w_cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_c[4];
        if (idx_q == IdxLast) begin
          cout_d  = slice_c[4];
          // On the top nibble, slice_a[3]/slice_b[3] are the operand sign bits
          ovf_d   = (slice_a[3] == slice_b[3]) && (slice_s[3] != slice_a[3]);
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_busy = (state_q != StIdle);
  assign w_done = (state_q == StDone);
  assign w_sum  = sum_q;
  assign w_cout = cout_q;
  assign w_ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: a NIB=4 and a NIB=1 instance.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, cin4, busy4, done4, cout4, ovf4;
  logic [15:0] a4, b4, sum4;
  logic        start1, cin1, busy1, done1, cout1, ovf1;
  logic [3:0]  a1, b1, sum1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIB(4)) u_dut4 (
    .w_clk(clk), .w_rst(rst), .w_start(start4), .w_a(a4), .w_b(b4), .w_cin(cin4),
    .w_busy(busy4), .w_done(done4), .w_sum(sum4), .w_cout(cout4), .w_ovf(ovf4)
  );

  nibble_serial_adder_ctrl #(.NIB(1)) u_dut1 (
    .w_clk(clk), .w_rst(rst), .w_start(start1), .w_a(a1), .w_b(b1), .w_cin(cin1),
    .w_busy(busy1), .w_done(done1), .w_sum(sum1), .w_cout(cout1), .w_ovf(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One NIB=4 operation; operands are scrambled after acceptance
  task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] esum, input logic ecout,
                      input logic eovf);
    int lat;
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~cin;
    lat = 0;
    while (!done4 && lat < 12) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, lat, 4);
    check_eq({tag, " sum"}, sum4, esum);
    check_eq({tag, " cout"}, cout4, ecout);
    check_eq({tag, " ovf"}, ovf4, eovf);
    check_eq({tag, " busy@done"}, busy4, 1);
    tick();
    check_eq({tag, " busy after"}, busy4, 0);
    check_eq({tag, " done after"}, done4, 0);
    check_eq({tag, " sum hold"}, sum4, esum);
  endtask

  task automatic run1(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] esum, input logic ecout, input logic eovf);
    int lat;
    a1 = a; b1 = b; cin1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0; a1 = ~a; b1 = ~b;
    lat = 0;
    while (!done1 && lat < 6) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, lat, 1);
    check_eq({tag, " sum"}, sum1, esum);
    check_eq({tag, " cout"}, cout1, ecout);
    check_eq({tag, " ovf"}, ovf1, eovf);
    tick();
    check_eq({tag, " busy after"}, busy1, 0);
  endtask

  initial begin
    int ndone;
    logic [15:0] seen;
    rst = 1'b1;
    start4 = 1'b0; a4 = 16'h0; b4 = 16'h0; cin4 = 1'b0;
    start1 = 1'b0; a1 = 4'h0; b1 = 4'h0; cin1 = 1'b0;
    tick(); tick();
    check_eq("rst busy", busy4, 0);
    check_eq("rst done", done4, 0);
    check_eq("rst sum", sum4, 0);
    check_eq("rst cout", cout4, 0);
    check_eq("rst ovf", ovf4, 0);
    check_eq("rst busy1", busy1, 0);
    rst = 1'b0;
    tick();

    run4("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run4("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run4("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run4("cin", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
    run4("cin wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Second start during RUN must be ignored
    a4 = 16'h1234; b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    ndone = 0; seen = 16'h0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        start4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555;
      end else if (c == 2) begin
        start4 = 1'b0;
      end
      if (done4) begin
        ndone++;
        seen = sum4;
      end
    end
    check_eq("ignore dones", ndone, 1);
    check_eq("ignore sum", seen, 16'h2345);

    // Reset mid-operation aborts without a done pulse
    a4 = 16'h0F0F; b4 = 16'h0101; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort busy", busy4, 0);
    check_eq("abort done", done4, 0);
    check_eq("abort sum", sum4, 0);
    check_eq("abort cout", cout4, 0);
    check_eq("abort ovf", ovf4, 0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done4) ndone++;
    end
    check_eq("abort no done", ndone, 0);
    run4("post abort", 16'h1000, 16'h2345, 1'b0, 16'h3345, 1'b0, 1'b0);

    // Start held high: accepted every NIB+2 cycles
    a4 = 16'h0001; b4 = 16'h0002; cin4 = 1'b0; start4 = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (done4) begin
        ndone++;
        check_eq($sformatf("held done cycle %0d", ndone), c, (ndone == 1) ? 4 : 10);
      end
    end
    start4 = 1'b0;
    check_eq("held done count", ndone, 2);
    check_eq("held sum", sum4, 16'h0003);
    tick(); tick();

    run1("nib1 3+4", 4'h3, 4'h4, 4'h7, 1'b0, 1'b0);
    run1("nib1 8+9", 4'h8, 4'h9, 4'h1, 1'b1, 1'b1);
    run1("nib1 1+9", 4'h1, 4'h9, 4'hA, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Multi-cycle sequencer that adds two wide operands through a single 4-bit ripple-adder slice, one nibble per clock, LSB nibble first.
- Carry is held in a register between nibbles.
- Sits between a requester (start/done handshake) and the shared 4-bit adder datapath.
- Trades area for latency, so wide additions reuse the existing 4-bit full-adder chain.

Parameters:
- NIB, 4, number of nibbles per operand; operand width W = 4*NIB; legal range 1..16.

Ports:
- w_clk  input  1  system clock; all state updates on rising edge
- w_rst  input  1  synchronous reset, active-high
- w_start  input  1  request; sampled only in IDLE
- w_a  input  W  operand A; latched on accepted start
- w_b  input  W  operand B; latched on accepted start
- w_cin  input  1  initial carry-in; latched on accepted start
- w_busy  output  1  high while an operation is in progress (RUN or DONE)
- w_done  output  1  one-cycle pulse; result valid
- w_sum  output  W  result register
- w_cout  output  1  carry out of the top nibble
- w_ovf  output  1  two's-complement overflow of the W-bit add

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high on w_clk.
  - Reset forces state=IDLE, nibble index=0, carry reg=0.
  - Reset forces w_busy=0, w_done=0, w_sum=0, w_cout=0, w_ovf=0.
  - Reset has priority over every other event.
- States: IDLE, RUN, DONE.
- IDLE:
  - w_busy=0, w_done=0.
  - If w_start=1 at an edge: latch w_a, w_b, w_cin; clear w_sum, w_cout and w_ovf to 0; set idx=0; go to RUN.
  - Otherwise w_sum, w_cout and w_ovf hold their previous result.
- RUN (w_busy=1), at each edge:
  - t = A[idx] + B[idx] + carry, as a 5-bit sum.
  - w_sum nibble idx <= t[3:0]; carry <= t[4].
  - If idx == NIB-1: w_cout <= t[4]; w_ovf <= (A[W-1]==B[W-1]) && (t[3]!=A[W-1]); go to DONE.
  - Otherwise idx <= idx+1.
- DONE:
  - w_busy=1, w_done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - If w_start is accepted at edge E0, RUN occupies edges E0+1..E0+NIB.
  - w_done is high in the cycle after edge E0+NIB.
  - w_busy is low again after edge E0+NIB+1.
  - Minimum start-to-start spacing is NIB+2 cycles.
- Boundary conditions:
  - w_start while w_busy=1 (RUN or DONE): ignored, no queuing, no effect on the operation in flight.
  - w_a, w_b, w_cin changing after acceptance: no effect; only the latched copies are used.
  - w_start held high continuously: a new operation is accepted on each IDLE edge, i.e. every NIB+2 cycles.
  - Reset during RUN or DONE: aborts immediately, no w_done pulse, outputs return to reset values.
  - Intermediate nibbles of w_sum may be observed during RUN but are not valid until w_done.
  - Final w_sum/w_cout/w_ovf are valid from the w_done cycle and hold until the next accepted start or reset.
  - NIB=1: a single RUN cycle; behaves as a registered 4-bit adder with 3-cycle handshake.
  - Arithmetic is modulo 2^W; the carry out of the top nibble appears only on w_cout.
- Adder slice: inside the block as a 4-bit ripple chain of full adders; carry-in is the carry register.

Test Plan:
- NIB=4, A=0x1234, B=0x4321, cin=0, start at E0 -> done pulse exactly after E0+4; sum=0x5555, cout=0, ovf=0; busy low after E0+5.
- NIB=4, A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all four nibbles).
- NIB=4, A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1.
- NIB=4, A=0x000F, B=0x0000, cin=1 -> sum=0x0010, cout=0.
- NIB=4, A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1.
- Second start pulsed at E0+2 with different operands -> ignored; first result unchanged; only one done pulse.
- Reset asserted at E0+2 -> no done pulse; next cycle busy=0, sum=0, cout=0, ovf=0; a subsequent start completes normally.
- NIB=1 instance, A=3, B=4 -> sum=7, done after E0+1.
- NIB=1 instance, A=8, B=9 -> sum=1, cout=1, ovf=1.
- NIB=1 instance, A=1, B=9 -> sum=10, cout=0, ovf=0.
